// File: rtl/sccb_writer_pkg.sv
// Shared definitions for the SCCB write master: FSM encodings, counter limits
// and the pin decode used to register scl/sda for each bus quarter.
package sccb_writer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BITS  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int START_Q = 2;
  localparam int STOP_Q  = 3;

  localparam logic [1:0] LAST_PHASE     = 2'd2;
  localparam logic [3:0] ACK_BIT        = 4'd8;
  localparam logic [1:0] LAST_QTR       = 2'd3;
  localparam logic [1:0] ACK_SAMPLE_QTR = 2'd2;

  localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h42;

  typedef struct packed {
    logic scl;
    logic sda;
    logic oe;
  } pins_t;

  localparam pins_t PINS_IDLE = '{scl: 1'b1, sda: 1'b1, oe: 1'b0};

  // Pin levels for one quarter; SDA only moves while SCL is low except the START/STOP edges
  function automatic pins_t pinsFor(input logic [1:0] state, input logic [1:0] qtr,
                                    input logic [3:0] bitIdx, input logic txBit);
    pins_t p;
    p = PINS_IDLE;
    case (state)
      ST_START: begin
        p.scl = (qtr == 2'd0);
        p.sda = 1'b0;
        p.oe  = 1'b1;
      end
      ST_BITS: begin
        p.scl = (qtr == 2'd1) || (qtr == 2'd2);
        p.sda = txBit;
        p.oe  = (bitIdx != ACK_BIT);
      end
      ST_STOP: begin
        p.scl = (qtr != 2'd0);
        p.sda = (qtr == 2'(STOP_Q - 1));
        p.oe  = 1'b1;
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sccb_writer_tick_gen.sv
// Quarter-period timebase: counts 0..CLK_DIV-1 while enabled and flags the
// last count of each SCL quarter.
module sccb_tick_gen #(
  parameter int CLK_DIV = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/sccb_writer.sv
// SCCB write master: sends {DEV_ADDR, reg_addr, reg_data} as three 9-bit phases
// framed by START/STOP and reports whether any 9th-bit sample read high.
module sccb_writer
  import sccb_writer_pkg::*;
#(
  parameter int          CLK_DIV  = 60,
  parameter logic [7:0]  DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bitIdx_q, bitIdx_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [26:0] shift_q, shift_d;
  logic        ackAcc_q, ackAcc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ackErr_q, ackErr_d;
  pins_t       pins_q, pins_d;
  logic        accept;
  logic        tick;

  assign accept = start && !busy_q;

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy_q),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitIdx_d = bitIdx_q;
    qtr_d    = qtr_q;
    shift_d  = shift_q;
    ackAcc_d = ackAcc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ackErr_d = ackErr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_START;
          phase_d  = 2'd0;
          bitIdx_d = 4'd0;
          qtr_d    = 2'd0;
          // Each 9th slot holds a 1 so the released line shifts out naturally
          shift_d  = {DEV_ADDR, 1'b1, reg_addr, 1'b1, reg_data, 1'b1};
          ackAcc_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (qtr_q == 2'(START_Q - 1)) begin
            state_d = ST_BITS;
            qtr_d   = 2'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      ST_BITS: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if ((bitIdx_q == ACK_BIT) && (qtr_q == ACK_SAMPLE_QTR)) begin
            ackAcc_d = ackAcc_q | sda_i;
          end
          if (qtr_q == LAST_QTR) begin
            shift_d = {shift_q[25:0], 1'b1};
            if (bitIdx_q == ACK_BIT) begin
              bitIdx_d = 4'd0;
              if (phase_q == LAST_PHASE) begin
                state_d = ST_STOP;
              end else begin
                phase_d = phase_q + 2'd1;
              end
            end else begin
              bitIdx_d = bitIdx_q + 4'd1;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (qtr_q == 2'(STOP_Q - 1)) begin
            state_d  = ST_IDLE;
            qtr_d    = 2'd0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            ackErr_d = ackAcc_q;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pins are registered from the next state so they change glitch-free with the quarter
    pins_d = pinsFor(state_d, qtr_d, bitIdx_d, shift_d[26]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= 2'd0;
      bitIdx_q <= 4'd0;
      qtr_q    <= 2'd0;
      shift_q  <= '1;
      ackAcc_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ackErr_q <= 1'b0;
      pins_q   <= PINS_IDLE;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitIdx_q <= bitIdx_d;
      qtr_q    <= qtr_d;
      shift_q  <= shift_d;
      ackAcc_q <= ackAcc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ackErr_q <= ackErr_d;
      pins_q   <= pins_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ackErr_q;
  assign scl     = pins_q.scl;
  assign sda_o   = pins_q.sda;
  assign sda_oe  = pins_q.oe;

endmodule

// File: tb/tb_sccb_writer.sv
// Bench for sccb_writer: directed and random writes decoded by a passive bus
// monitor with an ACK responder and an SCL/SDA protocol checker.
module tb_sccb_writer;

  localparam int CD       = 2;
  localparam int DONE_LAT = 1 + 113 * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] regAddr;
  logic [7:0] regData;
  logic       busy;
  logic       done;
  logic       ackErr;
  logic       scl;
  logic       sdaO;
  logic       sdaOe;
  logic       sdaI;

  logic [2:0] ackPlan = 3'b000;
  int         totalChecks = 0;
  int         badChecks = 0;

  int         bitsInByte = 0;
  int         byteCount = 0;
  int         stopCount = 0;
  int         highCount = 0;
  bit         highValid = 1'b0;
  bit         inTx = 1'b0;
  bit         legal;
  logic       prevScl = 1'b1;
  logic       prevLine = 1'b1;
  logic       prevOe = 1'b0;
  logic [7:0] shiftByte = 8'h00;
  logic [7:0] rxBytes[$];

  always #5 clk = ~clk;

  // Responder drives the 9th bit of each byte with the planned level, else the pull-up wins
  assign sdaI = sdaOe ? sdaO
              : ((bitsInByte == 8 && byteCount < 3) ? ackPlan[byteCount[1:0]] : 1'b1);

  sccb_writer #(.CLK_DIV(CD), .DEV_ADDR(8'h42)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reg_addr (regAddr),
    .reg_data (regData),
    .busy     (busy),
    .done     (done),
    .ack_err  (ackErr),
    .scl      (scl),
    .sda_o    (sdaO),
    .sda_oe   (sdaOe),
    .sda_i    (sdaI)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Passive monitor: decodes START/bytes/STOP and checks SDA stability and SCL high time
  always @(negedge clk) begin
    if (rst) begin
      bitsInByte = 0;
      byteCount  = 0;
      inTx       = 1'b0;
      highValid  = 1'b0;
      highCount  = 0;
    end else begin
      if (prevScl && scl) begin
        if (prevLine !== sdaI) begin
          legal = 1'b0;
          if (prevLine && !sdaI && !highValid && !inTx) begin
            legal      = 1'b1;
            inTx       = 1'b1;
            bitsInByte = 0;
            byteCount  = 0;
            rxBytes.delete();
          end else if (!prevLine && sdaI && inTx && byteCount == 3 && bitsInByte == 0) begin
            legal     = 1'b1;
            inTx      = 1'b0;
            highValid = 1'b0;
            stopCount++;
          end
          checkOutput("sda_stable_scl_high", {31'd0, legal}, 32'd1);
        end
        highCount++;
      end else if (!prevScl && scl) begin
        highValid = 1'b1;
        highCount = 1;
      end else if (prevScl && !scl) begin
        if (highValid) begin
          checkOutput("scl_high_time", highCount, 2 * CD);
          if (bitsInByte == 8) begin
            checkOutput("ack_sda_oe", {31'd0, prevOe}, 32'd0);
          end else begin
            shiftByte = {shiftByte[6:0], prevLine};
          end
          bitsInByte++;
          if (bitsInByte == 9) begin
            rxBytes.push_back(shiftByte);
            byteCount++;
            bitsInByte = 0;
          end
        end
        highValid = 1'b0;
      end
    end
    prevScl  = scl;
    prevLine = sdaI;
    prevOe   = sdaOe;
  end

  // kind: 0 plain, 1 pulse start at injectAt, 2 reset at injectAt, 3 hold start through done
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic [2:0] plan,
                               input int injectAt, input int kind, input bit chained);
    int         n;
    int         stopsBefore;
    logic [7:0] expBytes[3];
    logic [7:0] got;
    logic       expAck;
    expBytes = '{8'h42, a, d};
    expAck   = |plan;
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    regAddr     = a;
    regData     = d;
    ackPlan     = plan;
    stopsBefore = stopCount;
    @(posedge clk);
    #1;
    n = 1;
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    if (kind != 3) start = 1'b0;
    regAddr = 8'($urandom);
    regData = 8'($urandom);
    while (!done && n < DONE_LAT + 20) begin
      if (kind == 1) start = (n == injectAt);
      if (kind == 2 && n == injectAt) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_scl", {31'd0, scl}, 32'd1);
        checkOutput("abort_sda_oe", {31'd0, sdaOe}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (kind == 1) start = 1'b0;
    checkOutput("done_latency", n, DONE_LAT);
    checkOutput("ack_err", {31'd0, ackErr}, {31'd0, expAck});
    checkOutput("byte_count", rxBytes.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < rxBytes.size()) ? rxBytes[i] : 8'hxx;
      checkOutput($sformatf("rx_byte%0d", i), {24'd0, got}, {24'd0, expBytes[i]});
    end
    checkOutput("stop_seen", stopCount - stopsBefore, 1);
    if (kind == 3) return;
    @(posedge clk);
    #1;
    checkOutput("done_pulse_width", {31'd0, done}, 32'd0);
    checkOutput("idle_scl", {31'd0, scl}, 32'd1);
    checkOutput("idle_sda_oe", {31'd0, sdaOe}, 32'd0);
    checkOutput("ack_err_hold", {31'd0, ackErr}, {31'd0, expAck});
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    regAddr = 8'h00;
    regData = 8'h00;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("reset_scl", {31'd0, scl}, 32'd1);
      checkOutput("reset_sda_oe", {31'd0, sdaOe}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    applyStimulus(8'h12, 8'h80, 3'b000, 0, 0, 1'b0);
    applyStimulus(8'h34, 8'h56, 3'b100, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'($urandom), 8'($urandom), 3'($urandom), 0, 0, 1'b0);
    end

    applyStimulus(8'h5a, 8'ha5, 3'b001, 50, 1, 1'b0);

    applyStimulus(8'hc3, 8'h3c, 3'b010, 0, 3, 1'b0);
    applyStimulus(8'h77, 8'h88, 3'b000, 0, 0, 1'b1);

    // Bit 3 of phase 1 begins at quarter 50; abort in its first SCL-high quarter
    applyStimulus(8'hee, 8'hff, 3'b000, 1 + 51 * CD, 2, 1'b0);
    repeat (3) @(posedge clk);
    applyStimulus(8'h11, 8'h01, 3'b000, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
